forward_hazard_unit: RTL and testbench
======================================

// Module: forward_hazard_unit
// PURPOSE
//  Parametrised successor to the EX-stage forwarding mux. Forwards RS1/RS2 from NSTAGE younger
//  pipeline stages with youngest-wins priority and x0 suppression. Adds a load-use interlock and
//  a wait-for-memory interlock, driven by a small FSM, plus saturating stall/event counters for Zicsr HPM.
//  Sits between ID/EX and the pipeline-register control: stall, bubble and hold outputs go to the IF/ID/EX regs.
// PARAMETERS
//  XLEN      `XLEN   operand width
//  XADDR     `XADDR  register address width
//  NSTAGE    2       forwarding sources; index 0 = MEM (youngest), NSTAGE-1 = oldest (WB)
//  CNT_W     32      width of the performance counters
//  WAIT_MAX  64      consecutive MEM_WAIT cycles before the sticky timeout flag sets
// PORTS
//  i_clk             in   1              clock
//  i_rst_n           in   1              asynchronous, active-low reset
//  i_rs1_ex/i_rs2_ex in   XLEN           register-file operand values in EX
//  i_rs1_addr_ex/i_rs2_addr_ex in XADDR  EX source addresses
//  i_rs1_addr_id/i_rs2_addr_id in XADDR  ID source addresses
//  i_rs1_used_id/i_rs2_used_id in 1      ID instruction actually reads rsN
//  i_rd_addr_ex      in   XADDR          rd of the instruction in EX
//  i_load_ex         in   1              instruction in EX is a load with rd write enabled
//  i_rd_stage        in   NSTAGE*XLEN    rd values; stage k at [k*XLEN +: XLEN]
//  i_rd_addr_stage   in   NSTAGE*XADDR   rd addresses, same packing
//  i_rd_wr_en_stage  in   NSTAGE         rd write enable per stage
//  i_rd_valid_stage  in   NSTAGE         rd value is ready (0 = load data pending)
//  i_cnt_clr         in   1              synchronous clear of the counters and the timeout flag
//  o_rs1/o_rs2       out  XLEN           forwarded operands to the ALU
//  o_stall_id        out  1              hold PC and IF/ID
//  o_bubble_ex       out  1              load a NOP into ID/EX
//  o_hold_ex         out  1              hold PC, IF/ID and ID/EX; bubble into EX/MEM
//  o_state           out  2              FSM state (debug)
//  o_stall_cnt       out  CNT_W          cycles with o_stall_id or o_hold_ex asserted
//  o_lu_cnt          out  CNT_W          load-use interlocks taken
//  o_timeout         out  1              sticky: MEM_WAIT reached WAIT_MAX cycles
// BEHAVIOUR
//  Forwarding is combinational, zero latency, evaluated independently for rs1 and rs2:
//   - match[k] = wr_en[k] && addr_ex==rd_addr[k] && addr_ex!=0
//   - the lowest k with match[k] drives o_rsN = i_rd_stage[k]; with no match, o_rsN = i_rsN_ex
//   - rs2 selects only from the rs2 path (no rs1 cross-selection)
//  wait_ex = the selected k has i_rd_valid_stage[k]==0, for either operand -> o_hold_ex=1.
//  lu_hazard = i_load_ex && i_rd_addr_ex!=0 && (rs1_used && rs1_addr_id==rd_ex || same for rs2).
//   - lu_hazard && !wait_ex -> o_stall_id=1, o_bubble_ex=1
//   - wait_ex dominates: o_stall_id=1, o_hold_ex=1, o_bubble_ex=0
//  FSM (registered; encodings 0/1/2):
//   - IDLE     -> LOAD_USE when o_bubble_ex; -> MEM_WAIT when wait_ex
//   - LOAD_USE -> MEM_WAIT when wait_ex; -> LOAD_USE when o_bubble_ex; else -> IDLE
//   - MEM_WAIT -> stays while wait_ex; -> LOAD_USE when !wait_ex && o_bubble_ex; else -> IDLE
//  Counters:
//   - o_lu_cnt +1 on every cycle with o_bubble_ex
//   - o_stall_cnt +1 on every cycle with o_stall_id|o_hold_ex
//   - both saturate at all-ones
//   - i_cnt_clr has priority over increment; the clear-cycle event is not counted
//  Timeout:
//   - wait_len counts consecutive MEM_WAIT cycles; it resets on leaving MEM_WAIT and saturates at WAIT_MAX
//   - o_timeout sets when wait_len==WAIT_MAX and holds until i_cnt_clr
//  Reset (async assert, sync release): state=IDLE, counters=0, wait_len=0, o_timeout=0.
//   While i_rst_n=0: o_stall_id=o_bubble_ex=o_hold_ex=0; o_rsN still forward combinationally.
//   Reset during MEM_WAIT aborts the wait immediately with no counter update.
// STRUCTURE
//  header.vh: add FH_IDLE/FH_LOAD_USE/FH_MEM_WAIT state encodings; XLEN and XADDR are already there.
//  Sub-module fwd_operand_mux (NSTAGE, XLEN, XADDR): priority select and valid-of-selected output.
//   Instantiated once for rs1 and once for rs2; the FSM and counters live in the top level.
// TESTING
//  1. rs1=rs2=x5; MEM writes x5=0xAAAA, WB writes x5=0xBBBB -> o_rs1=o_rs2=0xAAAA; MEM wr_en=0 -> 0xBBBB.
//  2. EX addr x0, MEM writes x0=0x1234 with wr_en=1 -> o_rs1=i_rs1_ex; rs1=x3, rs2=x4 -> independent values.
//  3. load x7 in EX, ID rs2=x7 used -> o_stall_id=o_bubble_ex=1 for one cycle, state LOAD_USE, o_lu_cnt=1.
//  4. stage-0 match with valid=0 for 3 cycles -> o_hold_ex=1 for 3 cycles, state MEM_WAIT, o_stall_cnt+=3, then IDLE.
//  5. WAIT_MAX=4, valid held at 0 for 6 cycles -> o_timeout=1 from cycle 4; i_cnt_clr -> o_timeout=0 and counts=0.
//  6. CNT_W=3, 9 stall cycles -> o_stall_cnt=7; i_rst_n low mid-MEM_WAIT -> all stall outputs 0 and state IDLE at once.

Source files
------------

// File: rtl/forward_hazard_unit_pkg.sv
// Purpose: shared widths and FSM state encodings for the forwarding/hazard unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package forward_hazard_unit_pkg;

  localparam int FH_XLEN  = 32;
  localparam int FH_XADDR = 5;

  typedef enum logic [1:0] {
    FH_IDLE     = 2'd0,
    FH_LOAD_USE = 2'd1,
    FH_MEM_WAIT = 2'd2
  } fh_state_t;

endpackage

// File: rtl/forward_hazard_unit_fwd_operand_mux.sv
// Purpose: youngest-wins operand select across NSTAGE rd sources, x0 never forwarded.
// Latency: combinational, zero cycles.
// Backpressure: none; sel_vld reports whether the chosen source value is ready yet.
// Ports: src_addr/rf_dat = EX source address and register-file value;
//        stage_* = packed per-stage rd value/address/write-enable/ready (stage 0 youngest);
//        sel_dat/sel_hit/sel_vld = chosen operand, any-stage match, readiness of the chosen source.
module fwd_operand_mux #(
  parameter int NSTAGE = 2,
  parameter int XLEN   = 32,
  parameter int XADDR  = 5
) (
  input  logic [XADDR-1:0]        src_addr,
  input  logic [XLEN-1:0]         rf_dat,
  input  logic [NSTAGE*XLEN-1:0]  stage_dat,
  input  logic [NSTAGE*XADDR-1:0] stage_addr,
  input  logic [NSTAGE-1:0]       stage_wr_en,
  input  logic [NSTAGE-1:0]       stage_vld,
  output logic [XLEN-1:0]         sel_dat,
  output logic                    sel_hit,
  output logic                    sel_vld
);

  // Walk oldest to youngest so the lowest matching index is the last write.
  always_comb begin
    sel_dat = rf_dat;
    sel_hit = 1'b0;
    sel_vld = 1'b1;
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      if (stage_wr_en[k] && (src_addr != '0) &&
          (stage_addr[k*XADDR +: XADDR] == src_addr)) begin
        sel_dat = stage_dat[k*XLEN +: XLEN];
        sel_hit = 1'b1;
        sel_vld = stage_vld[k];
      end
    end
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// Purpose: EX operand forwarding plus load-use / wait-for-memory interlocks and HPM stall counters.
// Latency: forwarding and interlock outputs combinational; state, counters and timeout registered.
// Backpressure: raises o_stall_id / o_bubble_ex / o_hold_ex toward the IF/ID/EX pipeline registers.
// Ports: i_rs*_ex/i_rs*_addr_ex = EX operands; i_rs*_addr_id/i_rs*_used_id = ID sources;
//        i_rd_addr_ex/i_load_ex = EX load; i_rd_*_stage = packed forwarding sources;
//        i_cnt_clr = counter/timeout clear; o_rs1/o_rs2 = ALU operands; o_state, o_*_cnt, o_timeout = debug/HPM.
module forward_hazard_unit
  import forward_hazard_unit_pkg::*;
#(
  parameter int XLEN     = FH_XLEN,
  parameter int XADDR    = FH_XADDR,
  parameter int NSTAGE   = 2,
  parameter int CNT_W    = 32,
  parameter int WAIT_MAX = 64
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [XLEN-1:0]         i_rs1_ex,
  input  logic [XLEN-1:0]         i_rs2_ex,
  input  logic [XADDR-1:0]        i_rs1_addr_ex,
  input  logic [XADDR-1:0]        i_rs2_addr_ex,
  input  logic [XADDR-1:0]        i_rs1_addr_id,
  input  logic [XADDR-1:0]        i_rs2_addr_id,
  input  logic                    i_rs1_used_id,
  input  logic                    i_rs2_used_id,
  input  logic [XADDR-1:0]        i_rd_addr_ex,
  input  logic                    i_load_ex,
  input  logic [NSTAGE*XLEN-1:0]  i_rd_stage,
  input  logic [NSTAGE*XADDR-1:0] i_rd_addr_stage,
  input  logic [NSTAGE-1:0]       i_rd_wr_en_stage,
  input  logic [NSTAGE-1:0]       i_rd_valid_stage,
  input  logic                    i_cnt_clr,
  output logic [XLEN-1:0]         o_rs1,
  output logic [XLEN-1:0]         o_rs2,
  output logic                    o_stall_id,
  output logic                    o_bubble_ex,
  output logic                    o_hold_ex,
  output logic [1:0]              o_state,
  output logic [CNT_W-1:0]        o_stall_cnt,
  output logic [CNT_W-1:0]        o_lu_cnt,
  output logic                    o_timeout
);

  localparam int WL_W = $clog2(WAIT_MAX + 1);

  logic            rs1_hit, rs1_vld, rs2_hit, rs2_vld;
  logic            wait_ex, lu_hazard;
  fh_state_t       state_q, state_nxt;
  logic [WL_W-1:0] wait_len_q, wait_len_nxt;

  fwd_operand_mux #(.NSTAGE(NSTAGE), .XLEN(XLEN), .XADDR(XADDR)) u_mux_rs1 (
    .src_addr    (i_rs1_addr_ex),
    .rf_dat      (i_rs1_ex),
    .stage_dat   (i_rd_stage),
    .stage_addr  (i_rd_addr_stage),
    .stage_wr_en (i_rd_wr_en_stage),
    .stage_vld   (i_rd_valid_stage),
    .sel_dat     (o_rs1),
    .sel_hit     (rs1_hit),
    .sel_vld     (rs1_vld)
  );

  fwd_operand_mux #(.NSTAGE(NSTAGE), .XLEN(XLEN), .XADDR(XADDR)) u_mux_rs2 (
    .src_addr    (i_rs2_addr_ex),
    .rf_dat      (i_rs2_ex),
    .stage_dat   (i_rd_stage),
    .stage_addr  (i_rd_addr_stage),
    .stage_wr_en (i_rd_wr_en_stage),
    .stage_vld   (i_rd_valid_stage),
    .sel_dat     (o_rs2),
    .sel_hit     (rs2_hit),
    .sel_vld     (rs2_vld)
  );

  assign wait_ex   = (rs1_hit && !rs1_vld) || (rs2_hit && !rs2_vld);
  assign lu_hazard = i_load_ex && (i_rd_addr_ex != '0) &&
                     ((i_rs1_used_id && (i_rs1_addr_id == i_rd_addr_ex)) ||
                      (i_rs2_used_id && (i_rs2_addr_id == i_rd_addr_ex)));

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= FH_IDLE;
    else          state_q <= state_nxt;
  end

  // Next state: bubble already excludes wait_ex, so wait always takes precedence.
  always_comb begin
    state_nxt = FH_IDLE;
    if (wait_ex)        state_nxt = FH_MEM_WAIT;
    else if (lu_hazard) state_nxt = FH_LOAD_USE;
  end

  // Outputs. Interlocks are masked during reset so the pipeline regs never see a stale stall.
  always_comb begin
    o_state     = state_q;
    o_hold_ex   = i_rst_n && wait_ex;
    o_stall_id  = i_rst_n && (wait_ex || lu_hazard);
    o_bubble_ex = i_rst_n && lu_hazard && !wait_ex;
  end

  // wait_len tracks the length of the current wait run including the cycle being clocked,
  // so o_timeout rises on the same edge wait_len reaches WAIT_MAX.
  always_comb begin
    wait_len_nxt = '0;
    if (state_nxt == FH_MEM_WAIT)
      wait_len_nxt = (wait_len_q == WL_W'(WAIT_MAX)) ? wait_len_q : wait_len_q + WL_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wait_len_q  <= '0;
      o_timeout   <= 1'b0;
      o_stall_cnt <= '0;
      o_lu_cnt    <= '0;
    end else begin
      wait_len_q <= wait_len_nxt;
      if (i_cnt_clr) begin
        o_timeout   <= 1'b0;
        o_stall_cnt <= '0;
        o_lu_cnt    <= '0;
      end else begin
        if (wait_len_nxt == WL_W'(WAIT_MAX)) o_timeout <= 1'b1;
        if (o_stall_id && !(&o_stall_cnt))   o_stall_cnt <= o_stall_cnt + CNT_W'(1);
        if (o_bubble_ex && !(&o_lu_cnt))     o_lu_cnt    <= o_lu_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_forward_hazard_unit.sv
module tb_forward_hazard_unit;

  localparam int XLEN = 32, XADDR = 5, NSTAGE = 2, CNT_W = 3, WAIT_MAX = 4;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [XLEN-1:0]         rs1_ex, rs2_ex;
  logic [XADDR-1:0]        rs1_addr_ex, rs2_addr_ex, rs1_addr_id, rs2_addr_id, rd_addr_ex;
  logic                    rs1_used_id, rs2_used_id, load_ex, cnt_clr;
  logic [NSTAGE*XLEN-1:0]  rd_stage;
  logic [NSTAGE*XADDR-1:0] rd_addr_stage;
  logic [NSTAGE-1:0]       rd_wr_en_stage, rd_valid_stage;
  logic [XLEN-1:0]         o_rs1, o_rs2;
  logic                    stall_id, bubble_ex, hold_ex, timeout;
  logic [1:0]              state;
  logic [CNT_W-1:0]        stall_cnt, lu_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  forward_hazard_unit #(
    .XLEN(XLEN), .XADDR(XADDR), .NSTAGE(NSTAGE), .CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rs1_ex(rs1_ex), .i_rs2_ex(rs2_ex),
    .i_rs1_addr_ex(rs1_addr_ex), .i_rs2_addr_ex(rs2_addr_ex),
    .i_rs1_addr_id(rs1_addr_id), .i_rs2_addr_id(rs2_addr_id),
    .i_rs1_used_id(rs1_used_id), .i_rs2_used_id(rs2_used_id),
    .i_rd_addr_ex(rd_addr_ex), .i_load_ex(load_ex),
    .i_rd_stage(rd_stage), .i_rd_addr_stage(rd_addr_stage),
    .i_rd_wr_en_stage(rd_wr_en_stage), .i_rd_valid_stage(rd_valid_stage),
    .i_cnt_clr(cnt_clr),
    .o_rs1(o_rs1), .o_rs2(o_rs2),
    .o_stall_id(stall_id), .o_bubble_ex(bubble_ex), .o_hold_ex(hold_ex),
    .o_state(state), .o_stall_cnt(stall_cnt), .o_lu_cnt(lu_cnt), .o_timeout(timeout)
  );

  task automatic idle_inputs();
    rs1_ex = 32'h1111_0001; rs2_ex = 32'h2222_0002;
    rs1_addr_ex = '0; rs2_addr_ex = '0; rs1_addr_id = '0; rs2_addr_id = '0;
    rs1_used_id = 0; rs2_used_id = 0; rd_addr_ex = '0; load_ex = 0; cnt_clr = 0;
    rd_stage = '0; rd_addr_stage = '0; rd_wr_en_stage = '0; rd_valid_stage = '1;
  endtask

  task automatic set_stg(input int k, input logic [XADDR-1:0] a, input logic [XLEN-1:0] d,
                         input logic we, input logic v);
    rd_stage[k*XLEN +: XLEN]       = d;
    rd_addr_stage[k*XADDR +: XADDR] = a;
    rd_wr_en_stage[k]              = we;
    rd_valid_stage[k]              = v;
  endtask

  task automatic pulse_clr();
    @(negedge clk); cnt_clr = 1;
    @(negedge clk); cnt_clr = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    rs1_addr_ex = 5'd5; set_stg(0, 5'd5, 32'h55, 1, 0);
    load_ex = 1; rd_addr_ex = 5'd6; rs1_used_id = 1; rs1_addr_id = 5'd6;
    #1;
    checks++; if (o_rs1 !== 32'h55) begin errors++; $display("FAIL reset_fwd got=%h exp=%h", o_rs1, 32'h55); end
    checks++; if ({stall_id, bubble_ex, hold_ex} !== 3'b000) begin errors++; $display("FAIL reset_stall got=%b exp=000", {stall_id, bubble_ex, hold_ex}); end
    @(negedge clk); @(negedge clk);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if ({stall_cnt, lu_cnt, timeout} !== 7'd0) begin errors++; $display("FAIL reset_cnt got=%0d/%0d/%b exp=0/0/0", stall_cnt, lu_cnt, timeout); end
    idle_inputs();
    rst_n = 1;
  endtask

  task automatic test_forward();
    @(negedge clk);
    rs1_addr_ex = 5'd5; rs2_addr_ex = 5'd5;
    set_stg(0, 5'd5, 32'hAAAA, 1, 1); set_stg(1, 5'd5, 32'hBBBB, 1, 1);
    #1;
    checks++; if ({o_rs1, o_rs2} !== {32'hAAAA, 32'hAAAA}) begin errors++; $display("FAIL fwd_youngest got=%h/%h exp=aaaa/aaaa", o_rs1, o_rs2); end
    rd_wr_en_stage[0] = 0; #1;
    checks++; if ({o_rs1, o_rs2} !== {32'hBBBB, 32'hBBBB}) begin errors++; $display("FAIL fwd_wb got=%h/%h exp=bbbb/bbbb", o_rs1, o_rs2); end
    rd_wr_en_stage[1] = 0; #1;
    checks++; if ({o_rs1, o_rs2} !== {32'h1111_0001, 32'h2222_0002}) begin errors++; $display("FAIL fwd_none got=%h/%h exp=11110001/22220002", o_rs1, o_rs2); end
    idle_inputs();
  endtask

  task automatic test_x0_independent();
    @(negedge clk);
    set_stg(0, 5'd0, 32'h1234, 1, 1); #1;
    checks++; if (o_rs1 !== 32'h1111_0001) begin errors++; $display("FAIL x0_suppress got=%h exp=11110001", o_rs1); end
    rs1_addr_ex = 5'd3; rs2_addr_ex = 5'd4;
    set_stg(0, 5'd3, 32'h33, 1, 1); set_stg(1, 5'd4, 32'h44, 1, 1); #1;
    checks++; if ({o_rs1, o_rs2} !== {32'h33, 32'h44}) begin errors++; $display("FAIL indep got=%h/%h exp=33/44", o_rs1, o_rs2); end
    set_stg(1, 5'd9, 32'h99, 1, 1); #1;
    checks++; if ({o_rs1, o_rs2} !== {32'h33, 32'h2222_0002}) begin errors++; $display("FAIL no_cross got=%h/%h exp=33/22220002", o_rs1, o_rs2); end
    idle_inputs();
  endtask

  task automatic test_load_use();
    pulse_clr();
    load_ex = 1; rd_addr_ex = 5'd7; rs2_addr_id = 5'd7; rs2_used_id = 1; #1;
    checks++; if ({stall_id, bubble_ex, hold_ex} !== 3'b110) begin errors++; $display("FAIL lu_outputs got=%b exp=110", {stall_id, bubble_ex, hold_ex}); end
    @(negedge clk);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL lu_state got=%0d exp=1", state); end
    checks++; if ({lu_cnt, stall_cnt} !== {3'd1, 3'd1}) begin errors++; $display("FAIL lu_cnt got=%0d/%0d exp=1/1", lu_cnt, stall_cnt); end
    rs2_used_id = 0; #1;
    checks++; if ({stall_id, bubble_ex} !== 2'b00) begin errors++; $display("FAIL lu_unused got=%b exp=00", {stall_id, bubble_ex}); end
    rs2_used_id = 1; rd_addr_ex = 5'd0; rs2_addr_id = 5'd0; #1;
    checks++; if ({stall_id, bubble_ex} !== 2'b00) begin errors++; $display("FAIL lu_x0 got=%b exp=00", {stall_id, bubble_ex}); end
    @(negedge clk);
    checks++; if (state !== 2'd0 || lu_cnt !== 3'd1) begin errors++; $display("FAIL lu_after got=%0d/%0d exp=0/1", state, lu_cnt); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    pulse_clr();
    load_ex = 1; rd_addr_ex = 5'd8; rs1_addr_id = 5'd8; rs1_used_id = 1;
    @(negedge clk);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL b2b_state1 got=%0d exp=1", state); end
    @(negedge clk);
    checks++; if (state !== 2'd1 || lu_cnt !== 3'd2) begin errors++; $display("FAIL b2b_state2 got=%0d/%0d exp=1/2", state, lu_cnt); end
    idle_inputs();
    @(negedge clk);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL b2b_idle got=%0d exp=0", state); end
  endtask

  task automatic test_mem_wait();
    pulse_clr();
    checks++; if ({stall_cnt, lu_cnt} !== 6'd0) begin errors++; $display("FAIL clr_cnt got=%0d/%0d exp=0/0", stall_cnt, lu_cnt); end
    rs1_addr_ex = 5'd9; set_stg(0, 5'd9, 32'hD00D, 1, 0);
    load_ex = 1; rd_addr_ex = 5'd9; rs1_addr_id = 5'd9; rs1_used_id = 1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        @(negedge clk);
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL mw_state c%0d got=%0d exp=2", i, state); end
      end
      #1;
      checks++; if ({stall_id, bubble_ex, hold_ex} !== 3'b101) begin errors++; $display("FAIL mw_outputs c%0d got=%b exp=101", i, {stall_id, bubble_ex, hold_ex}); end
    end
    @(negedge clk);
    checks++; if (state !== 2'd2 || stall_cnt !== 3'd3) begin errors++; $display("FAIL mw_end got=%0d/%0d exp=2/3", state, stall_cnt); end
    idle_inputs(); #1;
    checks++; if (hold_ex !== 1'b0) begin errors++; $display("FAIL mw_release got=%b exp=0", hold_ex); end
    @(negedge clk);
    checks++; if (state !== 2'd0 || stall_cnt !== 3'd3 || lu_cnt !== 3'd0) begin errors++; $display("FAIL mw_idle got=%0d/%0d/%0d exp=0/3/0", state, stall_cnt, lu_cnt); end
  endtask

  task automatic test_timeout();
    pulse_clr();
    rs2_addr_ex = 5'd12; set_stg(1, 5'd12, 32'hC0, 1, 0);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      checks++; if (timeout !== (i >= WAIT_MAX)) begin errors++; $display("FAIL to_cycle%0d got=%b exp=%b", i, timeout, (i >= WAIT_MAX)); end
    end
    checks++; if (stall_cnt !== 3'd6) begin errors++; $display("FAIL to_stallcnt got=%0d exp=6", stall_cnt); end
    idle_inputs();
    @(negedge clk);
    checks++; if (timeout !== 1'b1 || state !== 2'd0) begin errors++; $display("FAIL to_sticky got=%b/%0d exp=1/0", timeout, state); end
    cnt_clr = 1;
    @(negedge clk); cnt_clr = 0;
    checks++; if ({timeout, stall_cnt, lu_cnt} !== 7'd0) begin errors++; $display("FAIL to_clr got=%b/%0d/%0d exp=0/0/0", timeout, stall_cnt, lu_cnt); end
  endtask

  task automatic test_saturate_reset();
    pulse_clr();
    rs1_addr_ex = 5'd13; set_stg(0, 5'd13, 32'hE0, 1, 0);
    repeat (9) @(negedge clk);
    checks++; if (stall_cnt !== 3'd7) begin errors++; $display("FAIL sat_cnt got=%0d exp=7", stall_cnt); end
    repeat (2) @(negedge clk);
    checks++; if (stall_cnt !== 3'd7 || state !== 2'd2) begin errors++; $display("FAIL sat_hold got=%0d/%0d exp=7/2", stall_cnt, state); end
    rst_n = 0; #1;
    checks++; if ({stall_id, bubble_ex, hold_ex} !== 3'b000 || state !== 2'd0) begin errors++; $display("FAIL rst_abort got=%b/%0d exp=000/0", {stall_id, bubble_ex, hold_ex}, state); end
    checks++; if ({stall_cnt, lu_cnt, timeout} !== 7'd0) begin errors++; $display("FAIL rst_cnt got=%0d/%0d/%b exp=0/0/0", stall_cnt, lu_cnt, timeout); end
    checks++; if (o_rs1 !== 32'hE0) begin errors++; $display("FAIL rst_fwd got=%h exp=e0", o_rs1); end
    @(negedge clk);
    idle_inputs(); rst_n = 1;
    @(negedge clk);
    checks++; if (state !== 2'd0 || stall_cnt !== 3'd0) begin errors++; $display("FAIL rst_release got=%0d/%0d exp=0/0", state, stall_cnt); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_x0_independent();
    test_load_use();
    test_back_to_back();
    test_mem_wait();
    test_timeout();
    test_saturate_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
